// File: rtl/read_data_pkg.sv
// +----------------------------------------------------------------------------+
// | read_data_pkg : FSM states, pixel-pair field layout, width helpers          |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package read_data_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VSYNC = 2'd1,
    ST_HSYNC = 2'd2,
    ST_DATA  = 2'd3
  } state_t;

  // Memory word is {R,G,B even, R,G,B odd}; each pixel is {R,G,B}.
  localparam int unsigned PIX_W    = 24;
  localparam int unsigned EVEN_LSB = 24;
  localparam int unsigned ODD_LSB  = 0;
  localparam int unsigned R_LSB    = 16;
  localparam int unsigned G_LSB    = 8;
  localparam int unsigned B_LSB    = 0;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned addr_width(input int unsigned w, input int unsigned h);
    return cnt_width(w * h / 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/read_data_threshold.sv
// +----------------------------------------------------------------------------+
// | read_data_threshold : binarizes one RGB pixel against 3*THRESHOLD           |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module read_data_threshold
  import read_data_pkg::*;
#(
  parameter int THRESHOLD = 90
) (
  input  logic [PIX_W-1:0] pix_i,
  output logic [PIX_W-1:0] pix_o
);

  localparam logic [9:0] c_LEVEL = 10'(3 * THRESHOLD);

  logic [9:0] w_sum;

  assign w_sum = 10'(pix_i[R_LSB +: 8]) + 10'(pix_i[G_LSB +: 8]) + 10'(pix_i[B_LSB +: 8]);
  assign pix_o = (w_sum > c_LEVEL) ? '1 : '0;

endmodule

`default_nettype wire

// File: rtl/read_data.sv
// +----------------------------------------------------------------------------+
// | read_data : streams a bottom-up stored frame top-down as pixel pairs with   |
// | vsync/hsync gaps. Define READ_THRESHOLD_EN to binarize pixels.              |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module read_data
  import read_data_pkg::*;
#(
  parameter  int IMAGE_WIDTH    = 768,
  parameter  int IMAGE_HEIGHT   = 512,
  parameter  int START_UP_DELAY = 100,
  parameter  int HSYNC_DELAY    = 160,
  parameter  int THRESHOLD      = 90,
  localparam int ADDR_W         = addr_width(IMAGE_WIDTH, IMAGE_HEIGHT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_Rd_En,
  output logic [ADDR_W-1:0] mem_Addr,
  input  logic [47:0]       mem_Rd_Data,
  output logic              vertical_Pulse,
  output logic              horizontal_Pulse,
  output logic [7:0]        data_Red_Even,
  output logic [7:0]        data_Green_Even,
  output logic [7:0]        data_Blue_Even,
  output logic [7:0]        data_Red_Odd,
  output logic [7:0]        data_Green_Odd,
  output logic [7:0]        data_Blue_Odd,
  output logic              sig_Read_Done
);

  localparam int HALF_W  = IMAGE_WIDTH / 2;
  localparam int MAX_DLY = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
  localparam int DLY_W   = cnt_width(MAX_DLY);
  localparam int ROW_W   = cnt_width(IMAGE_HEIGHT);
  localparam int COL_W   = cnt_width(HALF_W);

  if (IMAGE_WIDTH < 2 || (IMAGE_WIDTH % 2) != 0 || START_UP_DELAY < 1 ||
      HSYNC_DELAY < 1 || THRESHOLD < 0 || THRESHOLD > 255) begin : g_param_check
    $error("read_data: illegal parameter combination");
  end

  state_t            state_q;
  logic [DLY_W-1:0]  cnt_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_en_q;
  logic              vsync_q;
  logic              beat_q;
  logic              last_q;
  logic              done_q;
  logic [47:0]       pix_q;
  logic [47:0]       pix_d;

  logic              w_last_row;
  logic              w_last_col;
  logic [ADDR_W-1:0] w_row_base;
  logic [47:0]       w_pix;

  assign w_last_row = (row_q == ROW_W'(IMAGE_HEIGHT - 1));
  assign w_last_col = (col_q == COL_W'(HALF_W - 1));
  // BMP rows are stored bottom-up, so row 0 lives at the highest row base.
  assign w_row_base = ADDR_W'((IMAGE_HEIGHT - 1 - int'(row_q)) * HALF_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_VSYNC;
            cnt_q   <= '0;
            vsync_q <= 1'b1;
          end
        end
        ST_VSYNC: begin
          if (cnt_q == DLY_W'(START_UP_DELAY - 1)) begin
            state_q <= ST_HSYNC;
            cnt_q   <= '0;
            vsync_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_HSYNC: begin
          if (cnt_q == DLY_W'(HSYNC_DELAY - 1)) begin
            state_q <= ST_DATA;
            col_q   <= '0;
            addr_q  <= w_row_base;
            rd_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_last_col) begin
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            if (w_last_row) begin
              state_q <= ST_IDLE;
              row_q   <= '0;
            end else begin
              state_q <= ST_HSYNC;
              row_q   <= row_q + 1'b1;
            end
          end else begin
            col_q  <= col_q + 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef READ_THRESHOLD_EN
  logic [PIX_W-1:0] w_even_bin;
  logic [PIX_W-1:0] w_odd_bin;

  read_data_threshold #(.THRESHOLD(THRESHOLD)) u_thr_even (
    .pix_i (mem_Rd_Data[EVEN_LSB +: PIX_W]),
    .pix_o (w_even_bin)
  );

  read_data_threshold #(.THRESHOLD(THRESHOLD)) u_thr_odd (
    .pix_i (mem_Rd_Data[ODD_LSB +: PIX_W]),
    .pix_o (w_odd_bin)
  );

  assign w_pix = {w_even_bin, w_odd_bin};
`else
  assign w_pix = mem_Rd_Data;
`endif

  assign pix_d = rd_en_q ? w_pix : 48'd0;

  // Read data returns one cycle after the strobe, so beat/done trail the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q <= 1'b0;
      pix_q  <= '0;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      beat_q <= rd_en_q;
      pix_q  <= pix_d;
      last_q <= rd_en_q && w_last_row && w_last_col;
      done_q <= last_q;
    end
  end

  assign mem_Rd_En        = rd_en_q;
  assign mem_Addr         = addr_q;
  assign vertical_Pulse   = vsync_q;
  assign horizontal_Pulse = beat_q;
  assign sig_Read_Done    = done_q;
  assign data_Red_Even    = pix_q[EVEN_LSB + R_LSB +: 8];
  assign data_Green_Even  = pix_q[EVEN_LSB + G_LSB +: 8];
  assign data_Blue_Even   = pix_q[EVEN_LSB + B_LSB +: 8];
  assign data_Red_Odd     = pix_q[ODD_LSB + R_LSB +: 8];
  assign data_Green_Odd   = pix_q[ODD_LSB + G_LSB +: 8];
  assign data_Blue_Odd    = pix_q[ODD_LSB + B_LSB +: 8];

endmodule

`default_nettype wire

// File: tb/tb_read_data.sv
// +----------------------------------------------------------------------------+
// | tb_read_data : scoreboard bench for read_data (W=4, H=2, small delays)      |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_read_data;

  localparam int W      = 4;
  localparam int H      = 2;
  localparam int SUD    = 3;
  localparam int HD     = 2;
  localparam int THR    = 90;
  localparam int HALF   = W / 2;
  localparam int AW     = $clog2(W * H / 2);
  localparam int FRAME  = SUD + H * (HD + HALF);

  typedef struct {
    int          cyc;
    logic [47:0] val;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mem_Rd_En;
  logic [AW-1:0] mem_Addr;
  logic [47:0]   mem_Rd_Data;
  logic          vertical_Pulse;
  logic          horizontal_Pulse;
  logic [7:0]    data_Red_Even, data_Green_Even, data_Blue_Even;
  logic [7:0]    data_Red_Odd, data_Green_Odd, data_Blue_Odd;
  logic          sig_Read_Done;
  logic [47:0]   w_out;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_until = 0;
  int   last_done = 0;
  int   vp_lo = 1;
  int   vp_hi = 0;
  exp_t q_addr[$];
  exp_t q_data[$];
  int   q_done[$];

  read_data #(
    .IMAGE_WIDTH    (W),
    .IMAGE_HEIGHT   (H),
    .START_UP_DELAY (SUD),
    .HSYNC_DELAY    (HD),
    .THRESHOLD      (THR)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .mem_Rd_En        (mem_Rd_En),
    .mem_Addr         (mem_Addr),
    .mem_Rd_Data      (mem_Rd_Data),
    .vertical_Pulse   (vertical_Pulse),
    .horizontal_Pulse (horizontal_Pulse),
    .data_Red_Even    (data_Red_Even),
    .data_Green_Even  (data_Green_Even),
    .data_Blue_Even   (data_Blue_Even),
    .data_Red_Odd     (data_Red_Odd),
    .data_Green_Odd   (data_Green_Odd),
    .data_Blue_Odd    (data_Blue_Odd),
    .sig_Read_Done    (sig_Read_Done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [47:0] mem_word(input logic [AW-1:0] a);
    case (a)
      2'd0:    return {8'd91, 8'd91, 8'd91, 8'd90, 8'd90, 8'd90};
      2'd1:    return {8'd10, 8'd20, 8'd30, 8'd200, 8'd0, 8'd71};
      2'd2:    return 48'h1234_569A_BCDE;
      default: return 48'hFFFF_FF01_0203;
    endcase
  endfunction

  function automatic logic [23:0] exp_pix(input logic [23:0] p);
`ifdef READ_THRESHOLD_EN
    int s;
    s = int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
    return (s > 3 * THR) ? 24'hFFFFFF : 24'h000000;
`else
    return p;
`endif
  endfunction

  // Garbage on the bus while not reading exposes any missing output gating.
  assign mem_Rd_Data = mem_Rd_En ? mem_word(mem_Addr) : 48'hDEAD_BEEF_CAFE;
  assign w_out = {data_Red_Even, data_Green_Even, data_Blue_Even,
                  data_Red_Odd, data_Green_Odd, data_Blue_Odd};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_frame(input int t0);
    exp_t e;
    logic [47:0] w;
    vp_lo = t0 + 1;
    vp_hi = t0 + SUD;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < HALF; c++) begin
        e.cyc = t0 + SUD + 1 + r * (HD + HALF) + HD + c;
        e.val = 48'((H - 1 - r) * HALF + c);
        q_addr.push_back(e);
        w = mem_word(AW'((H - 1 - r) * HALF + c));
        e.cyc = e.cyc + 1;
        e.val = {exp_pix(w[47:24]), exp_pix(w[23:0])};
        q_data.push_back(e);
      end
    end
    last_done  = t0 + FRAME + 2;
    busy_until = t0 + FRAME + 1;
    q_done.push_back(last_done);
  endtask

  // Called just after a rising edge; start is sampled on the next edge.
  task automatic drive_start();
    start = 1'b1;
    if (cyc >= busy_until) push_frame(cyc);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_rd_en();
    int i;
    for (i = 0; i < 60 && !mem_Rd_En; i++) begin
      @(posedge clk); #1;
    end
    if (i == 60) check_eq("wait_rd_en_timeout", mem_Rd_En, 1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_rd_en"}, mem_Rd_En, 1'b0);
    check_eq({tag, "_addr"}, mem_Addr, '0);
    check_eq({tag, "_vpulse"}, vertical_Pulse, 1'b0);
    check_eq({tag, "_hpulse"}, horizontal_Pulse, 1'b0);
    check_eq({tag, "_data"}, w_out, '0);
    check_eq({tag, "_done"}, sig_Read_Done, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   d;
    while (q_addr.size() > 0 && q_addr[0].cyc < cyc) begin
      e = q_addr.pop_front();
      check_eq("rd_en_missed", cyc, e.cyc);
    end
    if (mem_Rd_En) begin
      if (q_addr.size() == 0) check_eq("rd_en_unexpected", mem_Rd_En, 1'b0);
      else begin
        e = q_addr.pop_front();
        check_eq("rd_en_cycle", cyc, e.cyc);
        check_eq("mem_addr", mem_Addr, e.val);
      end
    end
    while (q_data.size() > 0 && q_data[0].cyc < cyc) begin
      e = q_data.pop_front();
      check_eq("beat_missed", cyc, e.cyc);
    end
    if (horizontal_Pulse) begin
      if (q_data.size() == 0) check_eq("beat_unexpected", horizontal_Pulse, 1'b0);
      else begin
        e = q_data.pop_front();
        check_eq("beat_cycle", cyc, e.cyc);
        check_eq("pixel_data", w_out, e.val);
      end
    end else begin
      check_eq("data_idle_zero", w_out, '0);
    end
    check_eq("vertical_pulse", vertical_Pulse, (cyc >= vp_lo && cyc <= vp_hi));
    while (q_done.size() > 0 && q_done[0] < cyc) begin
      d = q_done.pop_front();
      check_eq("done_missed", cyc, d);
    end
    if (sig_Read_Done) begin
      if (q_done.size() == 0) check_eq("done_unexpected", sig_Read_Done, 1'b0);
      else begin
        d = q_done.pop_front();
        check_eq("done_cycle", cyc, d);
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Plain frame.
    drive_start();
    repeat (FRAME + 4) @(posedge clk);
    #1;

    // Start during the data phase must be ignored.
    drive_start();
    wait_rd_en();
    drive_start();
    repeat (FRAME + 4) @(posedge clk);
    #1;

    // Restart in the very cycle sig_Read_Done is high.
    drive_start();
    for (int i = 0; i < 100 && cyc < last_done; i++) begin
      @(posedge clk); #1;
    end
    check_eq("b2b_done_seen", sig_Read_Done, 1'b1);
    drive_start();
    repeat (FRAME + 4) @(posedge clk);
    #1;

    // Asynchronous reset during row 0.
    drive_start();
    wait_rd_en();
    reset = 1'b1;
    q_addr.delete();
    q_data.delete();
    q_done.delete();
    vp_lo = 1;
    vp_hi = 0;
    busy_until = 0;
    #1;
    check_outputs_zero("midframe_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    drive_start();
    repeat (FRAME + 4) @(posedge clk);
    #1;

    check_eq("pending_addr", q_addr.size(), 0);
    check_eq("pending_beats", q_data.size(), 0);
    check_eq("pending_done", q_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/read_data.md
READ_DATA -- requirements
Module: read_data

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 768, pixels per row (even, >= 2).
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 512, rows per frame.
REQ-003 SHALL have parameter START_UP_DELAY, default 100, cycles between start and the first row.
REQ-004 SHALL have parameter HSYNC_DELAY, default 160, idle cycles before each row.
REQ-005 SHALL have parameter THRESHOLD, default 90, binarization level (used only with REQ-026).
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  input  1  one-cycle frame request.
REQ-009 SHALL have port mem_Rd_En  output  1  pixel memory read strobe.
REQ-010 SHALL have port mem_Addr  output  ADDR_W = clog2(IMAGE_WIDTH*IMAGE_HEIGHT/2)  pixel-pair word address.
REQ-011 SHALL have port mem_Rd_Data  input  48  {R,G,B even, R,G,B odd}, valid 1 cycle after mem_Rd_En.
REQ-012 SHALL have port vertical_Pulse  output  1  high during frame start-up.
REQ-013 SHALL have port horizontal_Pulse  output  1  high on every valid pixel-pair beat.
REQ-014 SHALL have ports data_Red_Even, data_Green_Even, data_Blue_Even, data_Red_Odd, data_Green_Odd, data_Blue_Odd  output  8 each  pixel components.
REQ-015 SHALL have port sig_Read_Done  output  1  one-cycle end-of-frame pulse.

Function
REQ-016 SHALL implement FSM ST_IDLE -> ST_VSYNC -> ST_HSYNC -> ST_DATA -> (ST_HSYNC | ST_IDLE).
REQ-017 ST_IDLE SHALL move to ST_VSYNC on start=1; start SHALL be ignored in every other state.
REQ-018 ST_VSYNC SHALL last exactly START_UP_DELAY cycles with vertical_Pulse=1, then enter ST_HSYNC.
REQ-019 ST_HSYNC SHALL last exactly HSYNC_DELAY cycles with mem_Rd_En=0, then enter ST_DATA.
REQ-020 ST_DATA SHALL last exactly IMAGE_WIDTH/2 cycles, mem_Rd_En=1 each cycle, column counter 0..IMAGE_WIDTH/2-1.
REQ-021 mem_Addr SHALL equal (IMAGE_HEIGHT-1-row)*(IMAGE_WIDTH/2)+col, so rows are emitted top-down from bottom-up BMP storage.
REQ-022 After the last column of row IMAGE_HEIGHT-1, the FSM SHALL enter ST_IDLE; otherwise row increments and the FSM enters ST_HSYNC.
REQ-023 horizontal_Pulse and data_* SHALL be registered, one cycle after the matching mem_Rd_En; data_* SHALL be 0 when horizontal_Pulse=0.
REQ-024 sig_Read_Done SHALL pulse for one cycle, in the cycle after the last data beat; a start in that cycle SHALL be accepted.

Reset
REQ-025 reset=1 SHALL asynchronously force ST_IDLE, row=col=0 and all outputs to 0, including mid-frame; after release the block SHALL wait for a new start.

Configuration
REQ-026 With READ_THRESHOLD_EN defined, each pixel SHALL be output as 255 on all three channels if R+G+B (10-bit sum) > 3*THRESHOLD, else 0; latency unchanged.
REQ-027 Without READ_THRESHOLD_EN, pixel data SHALL pass through unmodified and THRESHOLD SHALL be unused.

Structure
REQ-028 Package read_data_pkg SHALL hold the FSM state enum, the 48-bit pixel-pair field offsets and the ADDR_W computation.
REQ-029 Binarization SHALL be the combinational sub-module read_data_threshold, instantiated twice (even, odd) only under READ_THRESHOLD_EN.

Verification (W=4, H=2, START_UP_DELAY=3, HSYNC_DELAY=2, memory word = address)
REQ-030 start at cycle 0 -> vertical_Pulse high for cycles 1-3; mem_Addr sequence 2,3 then 0,1; horizontal_Pulse high 2 beats per row.
REQ-031 full frame -> exactly 4 beats, 2 rows; sig_Read_Done high exactly once, the cycle after the 4th beat.
REQ-032 start pulsed during ST_DATA -> ignored; frame length and beat count unchanged.
REQ-033 reset asserted during row 0 -> all outputs 0 immediately; no sig_Read_Done; next start replays the full frame from address 2.
REQ-034 READ_THRESHOLD_EN, THRESHOLD=90, pixels (91,91,91) and (90,90,90) -> outputs 255/255/255 and 0/0/0.
REQ-035 start in the same cycle as sig_Read_Done -> second frame begins with no idle gap beyond START_UP_DELAY.
